icache_nway: RTL and testbench
==============================

Name: icache_nway

Overview:
- Parametrised, N-way set-associative, two-stage instruction cache; next generation of the fixed 2-way icache, sitting between IF and cache_axi.
- VIPT: set index from the virtual address, tag from the physical address.
- Adds over the previous generation: configurable ways, sets and line size; deterministic replacement; uncached single-word fetch; CACHE-instruction invalidate ops; fetch cancellation via cpu_if_valid_i.

Parameters:
- WAYS, 2, associativity; power of two, 1..4.
- SETS, 128, sets per way; power of two.
- LINE_WORDS, 8, 32-bit words per line; power of two, at least 2.
- Derived: OFFSET_W=log2(LINE_WORDS)+2, INDEX_W=log2(SETS), TAG_W=32-INDEX_W-OFFSET_W.
- Elaboration error if INDEX_W+OFFSET_W>12.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cpu_rreq_i  in  1  fetch request
- cpu_cached_i  in  1  1=cacheable, 0=uncached fetch
- cpu_virtual_addr_i  in  32  fetch VA (supplies the index)
- cpu_physical_addr_i  in  32  fetch PA (supplies the tag), valid in the request cycle
- cpu_bus_stall_i  in  1  pipeline stall; hold response, accept nothing
- cpu_if_valid_i  in  1  0 = pending fetch cancelled (branch/exception flush)
- cache_op_i  in  2  00 none, 01 index-invalidate, 10 hit-invalidate, 11 invalidate-all
- cache_op_vaddr_i  in  32  op VA (index)
- cache_op_paddr_i  in  32  op PA (tag, used by hit-invalidate)
- rend  in  1  AXI read complete; data valid this cycle
- cacheline_rdata_i  in  32*LINE_WORDS  refill line, word 0 in bits [31:0]
- icache_rreq_o  out  1  AXI read request
- icache_raddr_o  out  32  request address
- icache_uncached_o  out  1  1=single-word read, 0=line read
- cpu_stall_o  out  1  cache busy
- icache_rdata_o  out  32  instruction word
- icache_data_valid  out  1  icache_rdata_o valid

Behaviour:
- Reset: every valid bit 0, replacement pointers 0, state IDLE. All outputs 0.
- Storage: tag, valid and data arrays are flop-based per way and set. Read is combinational from the stage-1 registered index.
- States: IDLE, LOOKUP, MISS, REFILL, CACHEOP.
- Accept rule: a request is accepted when cpu_rreq_i=1, cpu_stall_o=0, cpu_bus_stall_i=0 and cache_op_i=00. Accepting latches VA, PA, cached and the offset into stage 1, then goes to LOOKUP.
- LOOKUP (cycle T+1):
  - Hit = cached and any way with valid=1 and tag==PA tag. At most one way matches.
  - On a hit: icache_data_valid=1 and icache_rdata_o=the selected word. A new request can be accepted in the same cycle (back-to-back 1/cycle throughput).
  - On a miss or uncached fetch: cpu_stall_o=1 combinationally, next state MISS.
- cpu_bus_stall_i=1 while a hit response is presented: stage 1 is frozen and data_valid/rdata are held stable until the stall drops.
- MISS:
  - icache_rreq_o=1 is held until rend.
  - Cached: raddr = line-aligned PA (offset bits zero), uncached_o=0.
  - Uncached: raddr = exact PA, uncached_o=1.
- On rend, go to REFILL:
  - Cached: write the line into the victim way, set valid, write the tag, advance that set's pointer.
  - Uncached: no install.
- REFILL (one cycle):
  - data_valid=1. rdata is the requested word from the captured line (cached) or captured bits [31:0] (uncached).
  - cpu_stall_o=0. Return to IDLE, or to LOOKUP if a new request is accepted this cycle.
- Victim selection: lowest-index invalid way; if all ways are valid, the set's round-robin pointer, which wraps from WAYS-1 to 0.
- Cancellation: cpu_if_valid_i=0 sampled in any cycle from LOOKUP-miss through REFILL sets a cancel flag.
  - The flag suppresses data_valid for that fetch.
  - The AXI transaction still completes and a cached line is still installed.
  - The flag clears on return to IDLE.
  - cpu_if_valid_i=0 during a LOOKUP hit suppresses data_valid in that cycle.
- Cache ops:
  - Accepted only in IDLE, or in LOOKUP with a hit. They take priority over a same-cycle cpu_rreq_i, which is not accepted.
  - cpu_stall_o=1 in the accept cycle and during CACHEOP (one cycle).
  - 01: clear valid for all ways of the indexed set.
  - 10: clear valid of the matching way only; no effect on a miss.
  - 11: clear all valid bits and reset all pointers.
- Reset asserted mid-MISS: everything returns to reset values immediately and icache_rreq_o drops. The AXI side must tolerate the abandoned request.

Test Plan:
Defaults are WAYS=2, SETS=128, LINE_WORDS=8. Set 2 holds tags 1/2/3 at 0x1040/0x2040/0x3040.
- Cold miss: fetch 0x00001048 cached. Required response:
  - T+1: stall=1.
  - MISS: rreq=1 with raddr=0x00001040, uncached_o=0.
  - rend with word k=0xA000000k: next cycle data_valid=1, rdata=0xA0000002.
  - Re-fetch of 0x0000104C hits at T+1 with 0xA0000003 and no rreq.
- Replacement: miss 0x1040, then miss 0x2040, then 0x1040 must hit. Miss 0x3040 evicts way 0 (pointer=0), so 0x1040 must miss again, while 0x2040 still hits.
- Uncached: fetch 0x1FC00004 with cached_i=0 -> raddr=0x1FC00004, uncached_o=1, rdata=cacheline_rdata_i[31:0]; the following identical fetch misses again.
- Cancel: cpu_if_valid_i=0 during MISS for 0x1040 -> data_valid stays 0 through REFILL; the next fetch of 0x1040 hits.
- Cache ops:
  - After filling 0x1040 and 0x2040, hit-invalidate PA 0x2040 -> 0x2040 misses, 0x1040 hits.
  - Invalidate-all -> both miss.
  - Issuing an op in the same cycle as cpu_rreq_i leaves the request unaccepted.
- Reset: assert rst while rreq=1 in MISS -> all outputs 0 in the same cycle; after release, 0x1040 misses.
- Bus stall: hit with cpu_bus_stall_i=1 for 3 cycles -> data_valid and rdata held constant for 3 cycles, no new accept.

Source files
------------

// File: rtl/icache_nway.sv
// N-way set-associative VIPT instruction cache: one-cycle lookup, single outstanding
// AXI refill, lowest-invalid/round-robin victim, CACHE-op invalidation, fetch cancel.
module icache_nway #(
  parameter int WAYS       = 2,
  parameter int SETS       = 128,
  parameter int LINE_WORDS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_rreq_i,
  input  logic                      cpu_cached_i,
  input  logic [31:0]               cpu_virtual_addr_i,
  input  logic [31:0]               cpu_physical_addr_i,
  input  logic                      cpu_bus_stall_i,
  input  logic                      cpu_if_valid_i,
  input  logic [1:0]                cache_op_i,
  input  logic [31:0]               cache_op_vaddr_i,
  input  logic [31:0]               cache_op_paddr_i,
  input  logic                      rend,
  input  logic [32*LINE_WORDS-1:0]  cacheline_rdata_i,
  output logic                      icache_rreq_o,
  output logic [31:0]               icache_raddr_o,
  output logic                      icache_uncached_o,
  output logic                      cpu_stall_o,
  output logic [31:0]               icache_rdata_o,
  output logic                      icache_data_valid
);
  localparam int WOFF_W   = $clog2(LINE_WORDS);
  localparam int OFFSET_W = WOFF_W + 2;
  localparam int INDEX_W  = $clog2(SETS);
  localparam int TAG_W    = 32 - INDEX_W - OFFSET_W;
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

  if (INDEX_W + OFFSET_W > 12 || WAYS < 1 || WAYS > 4 || LINE_WORDS < 2) begin : g_cfg_err
    $error("icache_nway: index+offset must fit the 4 KiB page, WAYS 1..4, LINE_WORDS >= 2");
  end

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REFILL, CACHEOP} state_e;

  state_e                      state_q, state_d;
  logic [INDEX_W-1:0]          index_q, op_index_q;
  logic [WOFF_W-1:0]           woff_q;
  logic [31:0]                 paddr_q;
  logic                        cached_q, cancel_q, cancel_d;
  logic [1:0]                  op_q;
  logic [TAG_W-1:0]            op_tag_q;
  logic [LINE_WORDS-1:0][31:0] line_q;
  logic [WAYS-1:0][SETS-1:0]   valid_q;
  logic [SETS-1:0][WAY_W-1:0]  rr_q;
  logic [TAG_W-1:0]            tag_q  [WAYS][SETS];
  logic [LINE_WORDS-1:0][31:0] data_q [WAYS][SETS];

  logic [TAG_W-1:0] ptag;
  logic             hit_any, hit, op_acc, acc, stall, install;
  logic [31:0]      hit_word;
  logic [WAY_W-1:0] victim, rr_next;
  logic [WAYS-1:0]  op_hit;
  logic             unused_ok;

  assign ptag    = paddr_q[31 -: TAG_W];
  assign hit     = cached_q & hit_any;
  assign install = (state_q == MISS) && rend && cached_q;
  assign rr_next = (rr_q[index_q] == WAY_W'(WAYS - 1)) ? '0 : rr_q[index_q] + WAY_W'(1);

  // Descending scan leaves the lowest-index invalid way as victim.
  always_comb begin
    hit_any  = 1'b0;
    hit_word = '0;
    victim   = rr_q[index_q];
    op_hit   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][index_q] && tag_q[w][index_q] == ptag) begin
        hit_any  = 1'b1;
        hit_word = data_q[w][index_q][woff_q];
      end
      op_hit[w] = valid_q[w][op_index_q] && (tag_q[w][op_index_q] == op_tag_q);
    end
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[w][index_q]) victim = WAY_W'(w);
  end

  always_comb begin
    op_acc  = (cache_op_i != 2'b00) && !cpu_bus_stall_i &&
              (state_q == IDLE || (state_q == LOOKUP && hit));
    stall   = (state_q == LOOKUP && !hit) || state_q == MISS || state_q == CACHEOP || op_acc;
    acc     = cpu_rreq_i && !stall && !cpu_bus_stall_i && (cache_op_i == 2'b00);
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (op_acc) state_d = CACHEOP; else if (acc) state_d = LOOKUP;
      LOOKUP: begin
        if (!hit)                state_d = MISS;
        else if (cpu_bus_stall_i) state_d = LOOKUP;
        else if (op_acc)         state_d = CACHEOP;
        else if (acc)            state_d = LOOKUP;
        else                     state_d = IDLE;
      end
      MISS:    if (rend) state_d = REFILL;
      REFILL: begin
        if (cpu_bus_stall_i) state_d = REFILL;
        else if (acc)        state_d = LOOKUP;
        else                 state_d = IDLE;
      end
      CACHEOP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cancel_d = cancel_q;
    if (!cpu_if_valid_i && ((state_q == LOOKUP && !hit) || state_q == MISS || state_q == REFILL))
      cancel_d = 1'b1;
    if (state_d == IDLE || state_d == LOOKUP) cancel_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cancel_q   <= 1'b0;
      index_q    <= '0;
      woff_q     <= '0;
      paddr_q    <= '0;
      cached_q   <= 1'b0;
      op_q       <= 2'b00;
      op_index_q <= '0;
      op_tag_q   <= '0;
      line_q     <= '0;
      valid_q    <= '0;
      rr_q       <= '0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      if (acc) begin
        index_q  <= cpu_virtual_addr_i[OFFSET_W +: INDEX_W];
        woff_q   <= cpu_virtual_addr_i[2 +: WOFF_W];
        paddr_q  <= cpu_physical_addr_i;
        cached_q <= cpu_cached_i;
      end
      if (op_acc) begin
        op_q       <= cache_op_i;
        op_index_q <= cache_op_vaddr_i[OFFSET_W +: INDEX_W];
        op_tag_q   <= cache_op_paddr_i[31 -: TAG_W];
      end
      if (state_q == MISS && rend) line_q <= cacheline_rdata_i;
      if (install) begin
        valid_q[victim][index_q] <= 1'b1;
        rr_q[index_q]            <= rr_next;
      end
      if (state_q == CACHEOP) begin
        unique case (op_q)
          2'b01: for (int w = 0; w < WAYS; w++) valid_q[w][op_index_q] <= 1'b0;
          2'b10: for (int w = 0; w < WAYS; w++) if (op_hit[w]) valid_q[w][op_index_q] <= 1'b0;
          2'b11: begin valid_q <= '0; rr_q <= '0; end
          default: ;
        endcase
      end
    end
  end

  // Tag/data contents are qualified by valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    if (install) begin
      tag_q[victim][index_q]  <= ptag;
      data_q[victim][index_q] <= cacheline_rdata_i;
    end
  end

  always_comb begin
    icache_rdata_o = '0;
    if (state_q == LOOKUP && hit)  icache_rdata_o = hit_word;
    else if (state_q == REFILL)    icache_rdata_o = cached_q ? line_q[woff_q] : line_q[0];
  end

  assign icache_rreq_o     = (state_q == MISS);
  assign icache_uncached_o = (state_q == MISS) && !cached_q;
  assign icache_raddr_o    = (state_q != MISS) ? '0 :
                             cached_q ? {paddr_q[31:OFFSET_W], {OFFSET_W{1'b0}}} : paddr_q;
  assign cpu_stall_o       = stall;
  assign icache_data_valid = cpu_if_valid_i &&
                             ((state_q == LOOKUP && hit) || (state_q == REFILL && !cancel_q));

  assign unused_ok = ^{cpu_virtual_addr_i[31:OFFSET_W+INDEX_W], cpu_virtual_addr_i[1:0],
                       cache_op_vaddr_i[31:OFFSET_W+INDEX_W], cache_op_vaddr_i[OFFSET_W-1:0],
                       cache_op_paddr_i[OFFSET_W+INDEX_W-1:0]};
endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway (2 ways, 128 sets, 8-word lines); expected values hand-derived.
module tb_icache_nway;
  logic         clk = 1'b0, rst;
  logic         cpu_rreq_i, cpu_cached_i, cpu_bus_stall_i, cpu_if_valid_i, rend;
  logic [31:0]  cpu_virtual_addr_i, cpu_physical_addr_i, cache_op_vaddr_i, cache_op_paddr_i;
  logic [1:0]   cache_op_i;
  logic [255:0] cacheline_rdata_i;
  logic         icache_rreq_o, icache_uncached_o, cpu_stall_o, icache_data_valid;
  logic [31:0]  icache_raddr_o, icache_rdata_o;

  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  icache_nway #(.WAYS(2), .SETS(128), .LINE_WORDS(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_rreq_i(cpu_rreq_i), .cpu_cached_i(cpu_cached_i),
    .cpu_virtual_addr_i(cpu_virtual_addr_i), .cpu_physical_addr_i(cpu_physical_addr_i),
    .cpu_bus_stall_i(cpu_bus_stall_i), .cpu_if_valid_i(cpu_if_valid_i),
    .cache_op_i(cache_op_i), .cache_op_vaddr_i(cache_op_vaddr_i), .cache_op_paddr_i(cache_op_paddr_i),
    .rend(rend), .cacheline_rdata_i(cacheline_rdata_i),
    .icache_rreq_o(icache_rreq_o), .icache_raddr_o(icache_raddr_o),
    .icache_uncached_o(icache_uncached_o), .cpu_stall_o(cpu_stall_o),
    .icache_rdata_o(icache_rdata_o), .icache_data_valid(icache_data_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic fetch(input logic [31:0] a, input logic c, input logic [31:0] lbase, input logic cxl,
                       output logic hit, output logic dv, output logic [31:0] rd,
                       output logic [31:0] ra, output logic un);
    logic [255:0] ln;
    nxt();
    cpu_rreq_i = 1'b1; cpu_virtual_addr_i = a; cpu_physical_addr_i = a; cpu_cached_i = c;
    #1 chk("accept_stall", cpu_stall_o, 0);
    nxt();
    cpu_rreq_i = 1'b0;
    #1;
    hit = !cpu_stall_o; dv = icache_data_valid; rd = icache_rdata_o; ra = '0; un = 1'b0;
    if (!hit) begin
      for (int i = 0; i < 8 && !icache_rreq_o; i++) begin nxt(); #1; end
      chk("rreq_seen", icache_rreq_o, 1);
      ra = icache_raddr_o; un = icache_uncached_o;
      for (int k = 0; k < 8; k++) ln[k*32 +: 32] = lbase | 32'(k);
      cacheline_rdata_i = ln; rend = 1'b1;
      if (cxl) cpu_if_valid_i = 1'b0;
      nxt();
      rend = 1'b0; cpu_if_valid_i = 1'b1;
      #1 dv = icache_data_valid; rd = icache_rdata_o;
    end
  endtask

  task automatic cop(input logic [1:0] op, input logic [31:0] a);
    nxt();
    cache_op_i = op; cache_op_vaddr_i = a; cache_op_paddr_i = a;
    #1 chk("op_accept_stall", cpu_stall_o, 1);
    nxt();
    cache_op_i = 2'b00;
    #1 chk("op_busy_stall", cpu_stall_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  initial begin
    logic h, dv, un;
    logic [31:0] rd, ra;
    rst = 1'b1; cpu_rreq_i = 0; cpu_cached_i = 0; cpu_bus_stall_i = 0; cpu_if_valid_i = 1;
    rend = 0; cache_op_i = 0; cpu_virtual_addr_i = 0; cpu_physical_addr_i = 0;
    cache_op_vaddr_i = 0; cache_op_paddr_i = 0; cacheline_rdata_i = '0;
    #12;
    chk("rst_rreq", icache_rreq_o, 0);   chk("rst_raddr", icache_raddr_o, 0);
    chk("rst_unc", icache_uncached_o, 0); chk("rst_stall", cpu_stall_o, 0);
    chk("rst_rdata", icache_rdata_o, 0);  chk("rst_dv", icache_data_valid, 0);
    nxt(); rst = 1'b0;

    fetch(32'h1048, 1, 32'hA000_0000, 0, h, dv, rd, ra, un);
    chk("cold_hit", h, 0); chk("cold_raddr", ra, 32'h1040); chk("cold_unc", un, 0);
    chk("cold_dv", dv, 1); chk("cold_rdata", rd, 32'hA000_0002);
    fetch(32'h104C, 1, 32'h0, 0, h, dv, rd, ra, un);
    chk("refetch_hit", h, 1); chk("refetch_dv", dv, 1); chk("refetch_rdata", rd, 32'hA000_0003);

    fetch(32'h2040, 1, 32'hB000_0000, 0, h, dv, rd, ra, un);
    chk("r2040_hit", h, 0); chk("r2040_rdata", rd, 32'hB000_0000);
    fetch(32'h1040, 1, 32'h0, 0, h, dv, rd, ra, un);
    chk("r1040_hit", h, 1); chk("r1040_rdata", rd, 32'hA000_0000);
    fetch(32'h3040, 1, 32'hC000_0000, 0, h, dv, rd, ra, un);
    chk("r3040_hit", h, 0); chk("r3040_raddr", ra, 32'h3040); chk("r3040_rdata", rd, 32'hC000_0000);
    fetch(32'h2040, 1, 32'h0, 0, h, dv, rd, ra, un);
    chk("r2040_kept", h, 1); chk("r2040_kept_rdata", rd, 32'hB000_0000);
    fetch(32'h1040, 1, 32'hD000_0000, 0, h, dv, rd, ra, un);
    chk("r1040_evicted", h, 0); chk("r1040_new_rdata", rd, 32'hD000_0000);

    fetch(32'h1FC0_0004, 0, 32'hE000_0000, 0, h, dv, rd, ra, un);
    chk("unc_hit", h, 0); chk("unc_raddr", ra, 32'h1FC0_0004); chk("unc_flag", un, 1);
    chk("unc_dv", dv, 1); chk("unc_rdata", rd, 32'hE000_0000);
    fetch(32'h1FC0_0004, 0, 32'hE100_0000, 0, h, dv, rd, ra, un);
    chk("unc_again_hit", h, 0); chk("unc_again_rdata", rd, 32'hE100_0000);

    cop(2'b11, 32'h0);
    fetch(32'h1040, 1, 32'hF000_0000, 1, h, dv, rd, ra, un);
    chk("cxl_hit", h, 0); chk("cxl_dv", dv, 0);
    fetch(32'h1040, 1, 32'h0, 0, h, dv, rd, ra, un);
    chk("cxl_installed", h, 1); chk("cxl_inst_rdata", rd, 32'hF000_0000);

    fetch(32'h2040, 1, 32'h9000_0000, 0, h, dv, rd, ra, un);
    chk("op_fill2040", h, 0);
    cop(2'b10, 32'h2040);
    fetch(32'h1040, 1, 32'h0, 0, h, dv, rd, ra, un);
    chk("hinv_1040_hit", h, 1); chk("hinv_1040_rdata", rd, 32'hF000_0000);
    fetch(32'h2040, 1, 32'h9100_0000, 0, h, dv, rd, ra, un);
    chk("hinv_2040_miss", h, 0); chk("hinv_2040_rdata", rd, 32'h9100_0000);

    cop(2'b11, 32'h0);
    fetch(32'h1040, 1, 32'h9200_0000, 0, h, dv, rd, ra, un);
    chk("iall_1040_miss", h, 0);
    fetch(32'h2040, 1, 32'h9300_0000, 0, h, dv, rd, ra, un);
    chk("iall_2040_miss", h, 0); chk("iall_2040_rdata", rd, 32'h9300_0000);

    nxt();
    cache_op_i = 2'b01; cache_op_vaddr_i = 32'h1040; cache_op_paddr_i = 32'h1040;
    cpu_rreq_i = 1; cpu_virtual_addr_i = 32'h1040; cpu_physical_addr_i = 32'h1040; cpu_cached_i = 1;
    #1 chk("opreq_stall", cpu_stall_o, 1);
    nxt(); cache_op_i = 2'b00; cpu_rreq_i = 0;
    #1 chk("opreq_busy", cpu_stall_o, 1); chk("opreq_no_dv", icache_data_valid, 0);
    nxt();
    #1 chk("opreq_idle_dv", icache_data_valid, 0); chk("opreq_idle_stall", cpu_stall_o, 0);
    fetch(32'h1040, 1, 32'h9400_0000, 0, h, dv, rd, ra, un);
    chk("iidx_1040_miss", h, 0); chk("iidx_1040_rdata", rd, 32'h9400_0000);

    nxt();
    cpu_rreq_i = 1; cpu_virtual_addr_i = 32'h1040; cpu_physical_addr_i = 32'h1040;
    nxt();
    cpu_virtual_addr_i = 32'h104C; cpu_physical_addr_i = 32'h104C; cpu_bus_stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) nxt();
      #1 chk("bstall_dv", icache_data_valid, 1); chk("bstall_rdata", icache_rdata_o, 32'h9400_0000);
    end
    nxt(); cpu_bus_stall_i = 0; cpu_rreq_i = 0;
    #1 chk("bstall_rel_dv", icache_data_valid, 1); chk("bstall_rel_rdata", icache_rdata_o, 32'h9400_0000);
    nxt();
    #1 chk("bstall_after_dv", icache_data_valid, 0);

    nxt();
    cpu_rreq_i = 1; cpu_virtual_addr_i = 32'h2040; cpu_physical_addr_i = 32'h2040;
    nxt(); cpu_rreq_i = 0;
    #1 chk("rstm_lookup_stall", cpu_stall_o, 1);
    nxt();
    #1 chk("rstm_rreq", icache_rreq_o, 1); chk("rstm_raddr", icache_raddr_o, 32'h2040);
    rst = 1'b1;
    #1 chk("rstm_rreq_drop", icache_rreq_o, 0); chk("rstm_raddr0", icache_raddr_o, 0);
    chk("rstm_stall0", cpu_stall_o, 0); chk("rstm_dv0", icache_data_valid, 0);
    nxt(); rst = 1'b0;
    fetch(32'h1040, 1, 32'h9500_0000, 0, h, dv, rd, ra, un);
    chk("post_rst_miss", h, 0); chk("post_rst_rdata", rd, 32'h9500_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
